dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising per-core data-memory accesses onto one shared memory.
// One memory operation in flight at a time; read data is returned per core with a one-cycle ack.
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic [NUM_CORES-1:0]          core_rd,
  input  logic [NUM_CORES-1:0]          core_wr,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES*DATA_W-1:0]   core_rdata,
  output logic [NUM_CORES-1:0]          core_ack,
  output logic [NUM_CORES-1:0]          core_stall,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  output logic                          mem_re,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          err_dual
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t               state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     winner;
  logic                 op_wr;
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] eligible;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     scan_idx;
  int                   scan_sum;

  assign req        = core_rd | core_wr;
  // A core being acked this cycle still shows its old request; it must not win again.
  assign eligible   = req & ~core_ack;
  assign core_stall = eligible;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = 0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_sum = int'(rr_ptr) + k;
      if (scan_sum >= NUM_CORES)
        scan_sum = scan_sum - NUM_CORES;
      scan_idx = PTR_W'(scan_sum);
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      winner     <= '0;
      op_wr      <= 1'b0;
      core_ack   <= '0;
      core_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      err_dual   <= 1'b0;
    end else begin
      core_ack <= '0;
      if (|(core_rd & core_wr))
        err_dual <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_found) begin
            // Write wins when both strobes are set; the read is simply dropped.
            winner    <= grant_idx;
            op_wr     <= core_wr[grant_idx];
            mem_addr  <= core_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            mem_wdata <= core_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            mem_we    <= core_wr[grant_idx];
            mem_re    <= ~core_wr[grant_idx];
            rr_ptr    <= (grant_idx == PTR_W'(NUM_CORES-1)) ? '0 : grant_idx + PTR_W'(1);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (op_wr) begin
            core_ack[winner] <= 1'b1;
            state            <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          core_rdata[int'(winner)*DATA_W +: DATA_W] <= mem_rdata;
          core_ack[winner] <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected memory ops and acks,
// a single monitor process compares them whenever the DUT presents them.
module tb_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct {
    int         core;
    bit         is_read;
    logic [15:0] data;
  } ack_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
  } mop_t;

  logic              clk = 1'b0;
  logic              RESET;
  logic [N-1:0]      core_rd;
  logic [N-1:0]      core_wr;
  logic [N*AW-1:0]   core_addr;
  logic [N*DW-1:0]   core_wdata;
  logic [N*DW-1:0]   core_rdata;
  logic [N-1:0]      core_ack;
  logic [N-1:0]      core_stall;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DW-1:0]     mem_rdata;
  logic              err_dual;

  ack_t        ack_q[$];
  mop_t        mop_q[$];
  int          checks;
  int          failures;
  int          timeouts;
  int          rem[N];
  bit          exp_err;
  bit          end_req;
  bit          end_done;
  logic [15:0] exp_rdata[N];
  logic [N*DW-1:0] exp_pack;
  ack_t        a_item;
  mop_t        m_item;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .RESET(RESET),
    .core_rd(core_rd), .core_wr(core_wr),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack), .core_stall(core_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .err_dual(err_dual)
  );

  // Memory model: registered read, contents are a fixed function of the address.
  function automatic logic [15:0] mem_value(input logic [15:0] addr);
    if (addr == 16'h0020)
      return 16'h1234;
    return addr ^ 16'hC3C3;
  endfunction

  always @(posedge clk)
    mem_rdata <= mem_re ? mem_value(mem_addr) : 16'hDEAD;

  function automatic ack_t mk_ack(input int core, input bit is_read, input logic [15:0] data);
    ack_t r;
    r.core    = core;
    r.is_read = is_read;
    r.data    = data;
    return r;
  endfunction

  function automatic mop_t mk_mop(input bit we, input logic [15:0] addr, input logic [15:0] data);
    mop_t r;
    r.we   = we;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

  // Monitor: the only process that makes comparisons or touches the counters.
  always @(negedge clk) begin
    if (RESET) begin
      checks++;
      if (core_ack !== '0 || core_rdata !== '0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
          mem_addr !== '0 || mem_wdata !== '0 || err_dual !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_state: ack=%h rdata=%h we=%b re=%b addr=%h wdata=%h err=%b, required all zero",
                 core_ack, core_rdata, mem_we, mem_re, mem_addr, mem_wdata, err_dual);
      end
      for (int i = 0; i < N; i++) exp_rdata[i] = '0;
    end else begin
      checks++;
      if (core_stall !== ((core_rd | core_wr) & ~core_ack)) begin
        failures++;
        $display("[TB] FAIL stall: got %b, required %b", core_stall, (core_rd | core_wr) & ~core_ack);
      end
      if (mem_we || mem_re) begin
        checks++;
        if (mop_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL mem_op_unexpected: we=%b re=%b addr=%h, required no memory op", mem_we, mem_re, mem_addr);
        end else begin
          m_item = mop_q.pop_front();
          if (mem_we !== m_item.we || mem_re !== !m_item.we || mem_addr !== m_item.addr ||
              (m_item.we && mem_wdata !== m_item.data)) begin
            failures++;
            $display("[TB] FAIL mem_op: got we=%b re=%b addr=%h wdata=%h, required we=%b re=%b addr=%h wdata=%h",
                     mem_we, mem_re, mem_addr, mem_wdata, m_item.we, !m_item.we, m_item.addr, m_item.data);
          end
        end
      end
      if (core_ack !== '0) begin
        checks++;
        if ($countones(core_ack) != 1 || ack_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL ack_unexpected: ack=%b pending=%0d, required one-hot ack with a pending request",
                   core_ack, ack_q.size());
        end else begin
          a_item = ack_q.pop_front();
          if (core_ack[a_item.core] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ack_order: got ack=%b, required core %0d", core_ack, a_item.core);
          end
          if (a_item.is_read) exp_rdata[a_item.core] = a_item.data;
          for (int i = 0; i < N; i++) exp_pack[i*DW +: DW] = exp_rdata[i];
          checks++;
          if (core_rdata !== exp_pack) begin
            failures++;
            $display("[TB] FAIL rdata: got %h, required %h", core_rdata, exp_pack);
          end
          checks++;
          if (err_dual !== exp_err) begin
            failures++;
            $display("[TB] FAIL err_dual: got %b, required %b", err_dual, exp_err);
          end
        end
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (ack_q.size() != 0 || mop_q.size() != 0 || timeouts != 0) begin
        failures++;
        $display("[TB] FAIL drain: acks left=%0d ops left=%0d timeouts=%0d, required 0/0/0",
                 ack_q.size(), mop_q.size(), timeouts);
      end
      end_done = 1'b1;
    end
  end

  task automatic apply_stimulus(input int c, input bit rd, input bit wr,
                                input logic [15:0] addr, input logic [15:0] data, input int count);
    core_rd[c]            = rd;
    core_wr[c]            = wr;
    core_addr[c*AW +: AW]  = addr;
    core_wdata[c*DW +: DW] = data;
    rem[c]                = count;
  endtask

  // Advance one cycle; a core drops its request once its last ack is seen.
  task automatic step();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (core_ack[i] && rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0) begin
          core_rd[i] = 1'b0;
          core_wr[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit busy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      step();
      n++;
      busy = 1'b0;
      for (int i = 0; i < N; i++) if (rem[i] > 0) busy = 1'b1;
    end
    if (busy) timeouts++;
    repeat (3) step();
  endtask

  task automatic do_reset();
    RESET   = 1'b1;
    core_rd = '0;
    core_wr = '0;
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (2) step();
    RESET = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    timeouts   = 0;
    end_req    = 1'b0;
    end_done   = 1'b0;
    exp_err    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
    do_reset();

    // Single write from core 1.
    mop_q.push_back(mk_mop(1'b1, 16'h0010, 16'hBEEF));
    ack_q.push_back(mk_ack(1, 1'b0, 16'h0000));
    apply_stimulus(1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1);
    wait_idle(20);

    // Single read from core 2.
    mop_q.push_back(mk_mop(1'b0, 16'h0020, 16'h0000));
    ack_q.push_back(mk_ack(2, 1'b1, 16'h1234));
    apply_stimulus(2, 1'b1, 1'b0, 16'h0020, 16'h0000, 1);
    wait_idle(20);

    // All four cores read together after reset: served 0,1,2,3.
    do_reset();
    mop_q.push_back(mk_mop(1'b0, 16'h0040, 16'h0000));
    mop_q.push_back(mk_mop(1'b0, 16'h0041, 16'h0000));
    mop_q.push_back(mk_mop(1'b0, 16'h0042, 16'h0000));
    mop_q.push_back(mk_mop(1'b0, 16'h0043, 16'h0000));
    ack_q.push_back(mk_ack(0, 1'b1, 16'hC383));
    ack_q.push_back(mk_ack(1, 1'b1, 16'hC382));
    ack_q.push_back(mk_ack(2, 1'b1, 16'hC381));
    ack_q.push_back(mk_ack(3, 1'b1, 16'hC380));
    apply_stimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1);
    apply_stimulus(1, 1'b1, 1'b0, 16'h0041, 16'h0000, 1);
    apply_stimulus(2, 1'b1, 1'b0, 16'h0042, 16'h0000, 1);
    apply_stimulus(3, 1'b1, 1'b0, 16'h0043, 16'h0000, 1);
    wait_idle(40);

    // Core 0 holds its request for three writes; core 3 gets the second grant.
    do_reset();
    mop_q.push_back(mk_mop(1'b1, 16'h0100, 16'h1111));
    mop_q.push_back(mk_mop(1'b1, 16'h0103, 16'h3333));
    mop_q.push_back(mk_mop(1'b1, 16'h0100, 16'h1111));
    mop_q.push_back(mk_mop(1'b1, 16'h0100, 16'h1111));
    ack_q.push_back(mk_ack(0, 1'b0, 16'h0000));
    ack_q.push_back(mk_ack(3, 1'b0, 16'h0000));
    ack_q.push_back(mk_ack(0, 1'b0, 16'h0000));
    ack_q.push_back(mk_ack(0, 1'b0, 16'h0000));
    apply_stimulus(0, 1'b0, 1'b1, 16'h0100, 16'h1111, 3);
    apply_stimulus(3, 1'b0, 1'b1, 16'h0103, 16'h3333, 1);
    wait_idle(40);

    // Dual rd+wr on core 0: becomes a write, error flag sticks across later traffic.
    do_reset();
    exp_err = 1'b1;
    mop_q.push_back(mk_mop(1'b1, 16'h0030, 16'h00AA));
    ack_q.push_back(mk_ack(0, 1'b0, 16'h0000));
    apply_stimulus(0, 1'b1, 1'b1, 16'h0030, 16'h00AA, 1);
    wait_idle(20);
    mop_q.push_back(mk_mop(1'b1, 16'h0031, 16'h0055));
    ack_q.push_back(mk_ack(1, 1'b0, 16'h0000));
    apply_stimulus(1, 1'b0, 1'b1, 16'h0031, 16'h0055, 1);
    wait_idle(20);

    // Reset while core 2's read sits in RESP: no ack, then service restarts at core 0.
    do_reset();
    mop_q.push_back(mk_mop(1'b0, 16'h0020, 16'h0000));
    apply_stimulus(2, 1'b1, 1'b0, 16'h0020, 16'h0000, 1);
    step();
    step();
    do_reset();
    repeat (3) step();
    mop_q.push_back(mk_mop(1'b0, 16'h0050, 16'h0000));
    mop_q.push_back(mk_mop(1'b0, 16'h0053, 16'h0000));
    ack_q.push_back(mk_ack(0, 1'b1, 16'hC393));
    ack_q.push_back(mk_ack(3, 1'b1, 16'hC390));
    apply_stimulus(0, 1'b1, 1'b0, 16'h0050, 16'h0000, 1);
    apply_stimulus(3, 1'b1, 1'b0, 16'h0053, 16'h0000, 1);
    wait_idle(30);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
    if (!end_done) begin
      $display("[TB] FAIL end_handshake: monitor did not finish, required completion");
      $fatal(1, "[TB] monitor stalled");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
